moore_seq_det: RTL and testbench
================================

# moore_seq_det

Parametrised Moore-style serial sequence detector, the generalised successor to the fixed zero-detect FSM. It watches a qualified serial bit stream and asserts a registered match output while the last accepted bits equal a run-time-loadable pattern of `PAT_W` bits. It supports overlapping and non-overlapping detection modes, exposes the FSM state, and keeps a saturating match counter. It sits in the FSM block library beside the existing detectors and is driven by testbench or peripheral serial sources.

## Interface

**Parameters**
- `PAT_W`, default 4: pattern length in bits; must be 2 or more.
- `CNT_W`, default 8: width of the match counter.

**Ports**
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `x_in`  in  1: serial data bit.
- `x_valid`  in  1: `x_in` is accepted on the rising edge only when high.
- `pattern`  in  `PAT_W`: pattern to detect; `pattern[PAT_W-1]` is the first bit in time. Sampled only on `load`.
- `overlap`  in  1: detection mode; 1 = overlapping, 0 = non-overlapping. Sampled only on `load`.
- `load`  in  1: latch `pattern` and `overlap`, and restart detection.
- `y_out`  out  1: Moore match flag.
- `state_out`  out  `SW = $clog2(PAT_W+1)`: current state, equal to the matched-prefix length.
- `match_count`  out  `CNT_W`: saturating count of matches.

## Operation

**State and history**
- State `S` runs from 0 to `PAT_W`. It is the number of leading pattern bits matched by the most recent accepted bits.
- `S == PAT_W` is the MATCH state.
- A history shift register `hist[PAT_W-1:0]` holds the last accepted bits.

**Next-state rule on an accepted bit `b`**
- Let `Smax = S + 1`, capped at `PAT_W`.
- Exception: in MATCH with `overlap = 0`, `Smax = 1` and history is treated as empty, so only `b` is considered.
- Next `S` is the largest `k <= Smax` such that the last `k` bits of `{hist, b}` equal `pattern[PAT_W-1 -: k]`. If no `k` qualifies, next `S` is 0.

**Outputs**
- `y_out = (S == PAT_W)`, driven from a register. It depends on state only, never on `x_in`.
- `state_out` is `S`.
- `match_count` increments by 1 on every accepted bit whose next state is MATCH, including staying in MATCH. It saturates at `2^CNT_W - 1`.

**Load**
- `pattern` and `overlap` are latched.
- `S` is set to 0, `hist` is cleared, and `match_count` is cleared.
- `x_in` is ignored that cycle, even if `x_valid` is high.

**Priority**
- `reset` > `load` > `x_valid`.

**Idle**
- When `x_valid` is low, `S`, `hist`, `match_count` and all outputs hold, regardless of `x_in`.

**Reset values**
- `S = 0`, `y_out = 0`, `state_out = 0`, `match_count = 0`, `hist = 0`.
- Pattern register = all zeros, overlap register = 1. The block therefore acts as a `PAT_W`-consecutive-zeros detector out of reset.

## Timing

- Bit accepted at edge N: `state_out`, `y_out` and `match_count` reflect it after edge N. Latency is one edge; there is no combinational input-to-output path.
- A match is visible on `y_out` for exactly one cycle per accepted bit and holds through `x_valid` gaps.
- Reset mid-stream, including in MATCH: all outputs return to their reset values after that edge, and the loaded pattern is lost.
- Load asserted in MATCH: `y_out` drops after that edge.
- Overlapping self-similar patterns (for example all zeros) keep `y_out` high and increment the count on every further matching bit.

## Structure

- Package `moore_seq_det_pkg`: helper function `state_w(PAT_W)` returning `$clog2(PAT_W+1)`, and reset constants for the pattern (`'0`) and overlap (`1'b1`).
- Sub-module `seq_prefix_match` (combinational):
  - Inputs: `hist`, `b`, `pattern`, `Smax`.
  - Output: next `S`.
  - Implementation: a generate loop of prefix/suffix comparators with a priority select of the largest match.
- The top level holds the registers, the load/reset priority logic and the counter.

## Test plan

1. **Default zero run.** Reset, then feed 0,0,0,0,0 with `x_valid = 1` → `y_out` rises after the 4th edge and stays high after the 5th; `match_count = 2`; `state_out = 4`.
2. **Overlapping mode.** Load `pattern = 4'b1011`, `overlap = 1`, then stream 1,0,1,1,0,1,1 → `y_out` is high after bits 4 and 7 only; `state_out` sequence is 1,2,3,4,2,3,4; `match_count = 2`.
3. **Non-overlapping mode.** Same stream with `overlap = 0` → `y_out` is high after bit 4 only; `state_out` after bit 5 is 0; `match_count = 1`.
4. **Valid gaps.** With pattern 1011 at `S = 3`, hold `x_valid` low for 5 cycles while toggling `x_in` → `state_out` stays 3. Then accept a single 1 → `y_out = 1`.
5. **Counter saturation.** With `CNT_W = 3`, default pattern, feed 12 zeros → 9 matches occur; `match_count` stops at 7 and `y_out` stays high.
6. **Reset and load priority.**
   - At `S = 3` with `x_valid = 1`, assert `reset` and `load` together → after the edge, all outputs are 0 and the pattern is 0000.
   - Assert `load` in MATCH → `y_out = 0` and count = 0 after the edge.

Source files
------------

// File: rtl/moore_seq_det_pkg.sv
// Shared helpers and reset constants for the parametrised Moore sequence detector.
package moore_seq_det_pkg;

    localparam logic PAT_RST_BIT = 1'b0;
    localparam logic OVERLAP_RST = 1'b1;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational next-state finder: longest pattern prefix (<= smax) that ends the window {hist, b}.
module seq_prefix_match
    import moore_seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int SW    = state_w(PAT_W)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic             b,
    input  logic [PAT_W-1:0] pattern,
    input  logic [SW-1:0]    smax,
    output logic [SW-1:0]    s_next
);

    logic [PAT_W:0] win;
    logic [PAT_W:1] hit;

    assign win = {hist, b};

    for (genvar k = 1; k <= PAT_W; k++) begin : g_cmp
        assign hit[k] = (win[k-1:0] == pattern[PAT_W-1 -: k]) && (SW'(k) <= smax);
    end

    // Ascending scan so the longest qualifying prefix wins.
    always_comb begin
        s_next = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            if (hit[k]) s_next = SW'(k);
        end
    end

endmodule

// File: rtl/moore_seq_det.sv
// Moore serial sequence detector with loadable pattern, overlap mode and saturating match count.
module moore_seq_det
    import moore_seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       x_in,
    input  logic                       x_valid,
    input  logic [PAT_W-1:0]           pattern,
    input  logic                       overlap,
    input  logic                       load,
    output logic                       y_out,
    output logic [state_w(PAT_W)-1:0]  state_out,
    output logic [CNT_W-1:0]           match_count
);

    localparam int SW = state_w(PAT_W);
    localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

    logic [SW-1:0]    s;
    logic [SW-1:0]    smax;
    logic [SW-1:0]    s_next;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat_r;
    logic             ovl_r;
    logic             y_r;
    logic [CNT_W-1:0] cnt;

    // Leaving MATCH without overlap restarts from the new bit alone.
    always_comb begin
        smax = s + SW'(1);
        if (s == S_MATCH) smax = ovl_r ? S_MATCH : SW'(1);
    end

    seq_prefix_match #(.PAT_W(PAT_W), .SW(SW)) u_match (
        .hist    (hist),
        .b       (x_in),
        .pattern (pat_r),
        .smax    (smax),
        .s_next  (s_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s     <= '0;
            hist  <= '0;
            pat_r <= {PAT_W{PAT_RST_BIT}};
            ovl_r <= OVERLAP_RST;
            y_r   <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            s     <= '0;
            hist  <= '0;
            pat_r <= pattern;
            ovl_r <= overlap;
            y_r   <= 1'b0;
            cnt   <= '0;
        end else if (x_valid) begin
            s    <= s_next;
            hist <= {hist[PAT_W-2:0], x_in};
            y_r  <= (s_next == S_MATCH);
            if (s_next == S_MATCH && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
    end

    assign y_out       = y_r;
    assign state_out   = s;
    assign match_count = cnt;

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed self-checking bench for moore_seq_det (default and 3-bit-counter instances).
module tb_moore_seq_det;

    logic       clock = 1'b0;
    logic       reset, x_in, x_valid, overlap, load;
    logic [3:0] pattern;
    logic       y_out, y_sat;
    logic [2:0] state_out, st_sat;
    logic [7:0] match_count;
    logic [2:0] cnt_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    moore_seq_det #(.PAT_W(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .pattern(pattern), .overlap(overlap), .load(load),
        .y_out(y_out), .state_out(state_out), .match_count(match_count)
    );

    moore_seq_det #(.PAT_W(4), .CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .pattern(pattern), .overlap(overlap), .load(load),
        .y_out(y_sat), .state_out(st_sat), .match_count(cnt_sat)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        reset = 1'b0; load = 1'b0; x_valid = 1'b0;
    endtask

    task automatic feed(input logic b);
        x_valid = 1'b1; x_in = b;
        tick();
    endtask

    task automatic do_load(input logic [3:0] p, input logic ov);
        load = 1'b1; pattern = p; overlap = ov; x_valid = 1'b1; x_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; x_valid = 1'b1; x_in = 1'b0;
        tick();
        n_checks++;
        if (y_out !== 1'b0 || state_out !== 3'd0 || match_count !== 8'd0) begin
            $display("FAIL reset: y=%b s=%0d cnt=%0d want 0/0/0", y_out, state_out, match_count);
            n_fail++;
        end
    endtask

    task automatic test_default_zero();
        int exp_s[5] = '{1, 2, 3, 4, 4};
        logic exp_y[5] = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            feed(1'b0);
            n_checks++;
            if (state_out !== 3'(exp_s[i]) || y_out !== exp_y[i]) begin
                $display("FAIL zero_run bit%0d: s=%0d y=%b want s=%0d y=%b",
                         i + 1, state_out, y_out, exp_s[i], exp_y[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (match_count !== 8'd2) begin
            $display("FAIL zero_run count: got %0d want 2", match_count);
            n_fail++;
        end
    endtask

    task automatic test_mode(input logic ov);
        logic stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        int exp_ov[7] = '{1, 2, 3, 4, 2, 3, 4};
        int exp_no[7] = '{1, 2, 3, 4, 0, 1, 1};
        int es;
        do_load(4'b1011, ov);
        n_checks++;
        if (state_out !== 3'd0 || match_count !== 8'd0 || y_out !== 1'b0) begin
            $display("FAIL load_ov%0b: s=%0d cnt=%0d y=%b want 0/0/0", ov, state_out, match_count, y_out);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) begin
            feed(stream[i]);
            es = ov ? exp_ov[i] : exp_no[i];
            n_checks++;
            if (state_out !== 3'(es) || y_out !== (es == 4)) begin
                $display("FAIL mode_ov%0b bit%0d: s=%0d y=%b want s=%0d y=%b",
                         ov, i + 1, state_out, y_out, es, (es == 4));
                n_fail++;
            end
        end
        n_checks++;
        if (match_count !== (ov ? 8'd2 : 8'd1)) begin
            $display("FAIL mode_ov%0b count: got %0d want %0d", ov, match_count, ov ? 2 : 1);
            n_fail++;
        end
    endtask

    task automatic test_valid_gaps();
        do_load(4'b1011, 1'b1);
        feed(1'b1); feed(1'b0); feed(1'b1);
        for (int i = 0; i < 5; i++) begin
            x_valid = 1'b0; x_in = i[0];
            @(posedge clock); #1;
            n_checks++;
            if (state_out !== 3'd3 || y_out !== 1'b0 || match_count !== 8'd0) begin
                $display("FAIL gap cyc%0d: s=%0d y=%b cnt=%0d want 3/0/0", i, state_out, y_out, match_count);
                n_fail++;
            end
        end
        feed(1'b1);
        n_checks++;
        if (y_out !== 1'b1 || state_out !== 3'd4 || match_count !== 8'd1) begin
            $display("FAIL gap_resume: y=%b s=%0d cnt=%0d want 1/4/1", y_out, state_out, match_count);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) feed(1'b0);
        n_checks++;
        if (cnt_sat !== 3'd7 || y_sat !== 1'b1) begin
            $display("FAIL sat: cnt=%0d y=%b want 7/1", cnt_sat, y_sat);
            n_fail++;
        end
        n_checks++;
        if (match_count !== 8'd9 || st_sat !== 3'd4) begin
            $display("FAIL sat_wide: cnt=%0d s=%0d want 9/4", match_count, st_sat);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        do_load(4'b1011, 1'b1);
        feed(1'b1); feed(1'b0); feed(1'b1);
        reset = 1'b1; load = 1'b1; pattern = 4'b1011; overlap = 1'b0;
        x_valid = 1'b1; x_in = 1'b1;
        tick();
        n_checks++;
        if (y_out !== 1'b0 || state_out !== 3'd0 || match_count !== 8'd0) begin
            $display("FAIL rst_load: y=%b s=%0d cnt=%0d want 0/0/0", y_out, state_out, match_count);
            n_fail++;
        end
        // Reset pattern is 0000 with overlap: four zeros must match.
        for (int i = 0; i < 4; i++) feed(1'b0);
        n_checks++;
        if (y_out !== 1'b1 || match_count !== 8'd1) begin
            $display("FAIL rst_pattern: y=%b cnt=%0d want 1/1", y_out, match_count);
            n_fail++;
        end
        do_load(4'b0000, 1'b1);
        n_checks++;
        if (y_out !== 1'b0 || match_count !== 8'd0 || state_out !== 3'd0) begin
            $display("FAIL load_in_match: y=%b cnt=%0d s=%0d want 0/0/0", y_out, match_count, state_out);
            n_fail++;
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; x_valid = 1'b0; x_in = 1'b0;
        pattern = 4'b0000; overlap = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_default_zero();
        test_mode(1'b1);
        test_mode(1'b0);
        test_valid_gaps();
        test_saturation();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
